// File: rtl/draw_pkg.sv
// Shared state encoding and helper functions for the sprite draw engine.
// Pure declarations: no latency, no flow control.
package draw_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t SCAN = 2'd1;
    localparam state_t DRAW = 2'd2;
    localparam state_t DONE = 2'd3;

    // Address width for n entries, never narrower than one bit.
    function automatic int clog2(input int n);
        int r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic int lowest_set(input logic [15:0] m);
        int idx = 0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/sprite_pixel_counter.sv
// Row-major sprite-local address generator; one address per enabled cycle.
// Zero-latency last flag; no backpressure, en simply holds the position.
module sprite_pixel_counter
    import draw_pkg::*;
#(
    parameter int SPR_W = 10,
    parameter int SPR_H = 6,
    parameter int XW    = clog2(SPR_W),
    parameter int YW    = clog2(SPR_H)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic          i_en,
    output logic [XW-1:0] o_rd_x,
    output logic [YW-1:0] o_rd_y,
    output logic          o_last
);

    localparam logic [XW-1:0] X_LAST = XW'(SPR_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SPR_H - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_row_end;

    assign w_row_end = (r_x == X_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_en) begin
            if (w_row_end) begin
                r_x <= '0;
                r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_rd_x = r_x;
    assign o_rd_y = r_y;
    assign o_last = w_row_end && (r_y == Y_LAST);

endmodule

// File: rtl/sprite_draw_engine.sv
// Multi-channel sprite blitter: draws enabled channels low-to-high, streaming ROM pixels to the VGA adapter.
// Pixel appears 1 cycle after its ROM address; no backpressure, start is only accepted while idle.
module sprite_draw_engine
    import draw_pkg::*;
#(
    parameter int                 NUM_SPRITES       = 4,
    parameter int                 WIDTH_X           = 9,
    parameter int                 WIDTH_Y           = 9,
    parameter int                 SPR_W             = 10,
    parameter int                 SPR_H             = 6,
    parameter int                 SCREEN_W          = 320,
    parameter int                 SCREEN_H          = 240,
    parameter int                 COLOR_W           = 3,
    parameter bit                 TRANSPARENT_EN    = 1'b1,
    parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = 3'b101,
    parameter int                 SEL_W             = clog2(NUM_SPRITES),
    parameter int                 XW                = clog2(SPR_W),
    parameter int                 YW                = clog2(SPR_H)
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_start,
    input  logic [NUM_SPRITES-1:0]         i_enable_mask,
    input  logic [NUM_SPRITES*WIDTH_X-1:0] i_pos_x,
    input  logic [NUM_SPRITES*WIDTH_Y-1:0] i_pos_y,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [SEL_W-1:0]               o_rd_sel,
    output logic [XW-1:0]                  o_rd_x,
    output logic [YW-1:0]                  o_rd_y,
    input  logic [COLOR_W-1:0]             i_rd_color,
    output logic                           o_plot,
    output logic [WIDTH_X-1:0]             o_x,
    output logic [WIDTH_Y-1:0]             o_y,
    output logic [COLOR_W-1:0]             o_color
);

    localparam logic [WIDTH_X:0] LIM_X = (WIDTH_X + 1)'(SCREEN_W);
    localparam logic [WIDTH_Y:0] LIM_Y = (WIDTH_Y + 1)'(SCREEN_H);

    state_t                         r_state;
    state_t                         w_next;
    logic [NUM_SPRITES-1:0]         r_mask;
    logic [NUM_SPRITES*WIDTH_X-1:0] r_pos_x;
    logic [NUM_SPRITES*WIDTH_Y-1:0] r_pos_y;
    logic [SEL_W-1:0]               r_sel;
    logic                           r_valid_d;
    logic                           r_off_d;
    logic [WIDTH_X-1:0]             r_x;
    logic [WIDTH_Y-1:0]             r_y;

    logic                           w_busy;
    logic                           w_done;
    logic                           w_clear;
    logic                           w_en;
    logic                           w_last;
    logic [XW-1:0]                  w_rd_x;
    logic [YW-1:0]                  w_rd_y;
    logic [15:0]                    w_mask16;
    logic [WIDTH_X:0]               w_sx;
    logic [WIDTH_Y:0]               w_sy;
    logic                           w_off;
    logic                           w_key;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = SCAN;
            SCAN:    w_next = (r_mask == '0) ? DONE : DRAW;
            DRAW:    if (w_last) w_next = SCAN;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy  = (r_state != IDLE);
        w_done  = (r_state == DONE);
        w_clear = (r_state == SCAN);
        w_en    = (r_state == DRAW);
    end

    always_comb begin
        w_mask16                  = '0;
        w_mask16[NUM_SPRITES-1:0] = r_mask;
    end

    // Each SCAN retires the lowest pending channel, which gives ascending painter order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mask  <= '0;
            r_pos_x <= '0;
            r_pos_y <= '0;
            r_sel   <= '0;
        end else if (r_state == IDLE && i_start) begin
            r_mask  <= i_enable_mask;
            r_pos_x <= i_pos_x;
            r_pos_y <= i_pos_y;
        end else if (r_state == SCAN && r_mask != '0) begin
            r_sel  <= SEL_W'(lowest_set(w_mask16));
            r_mask <= r_mask & (r_mask - NUM_SPRITES'(1));
        end
    end

    sprite_pixel_counter #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .XW    (XW),
        .YW    (YW)
    ) u_counter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_clear),
        .i_en    (w_en),
        .o_rd_x  (w_rd_x),
        .o_rd_y  (w_rd_y),
        .o_last  (w_last)
    );

    // One extra bit keeps the carry, so positions near the top of the range clip instead of wrapping.
    assign w_sx  = {1'b0, r_pos_x[int'(r_sel)*WIDTH_X +: WIDTH_X]} + (WIDTH_X + 1)'(w_rd_x);
    assign w_sy  = {1'b0, r_pos_y[int'(r_sel)*WIDTH_Y +: WIDTH_Y]} + (WIDTH_Y + 1)'(w_rd_y);
    assign w_off = (w_sx >= LIM_X) || (w_sy >= LIM_Y);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid_d <= 1'b0;
            r_off_d   <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
        end else begin
            r_valid_d <= w_en;
            if (w_en) begin
                r_off_d <= w_off;
                r_x     <= w_sx[WIDTH_X-1:0];
                r_y     <= w_sy[WIDTH_Y-1:0];
            end
        end
    end

    assign w_key    = TRANSPARENT_EN && (i_rd_color == TRANSPARENT_COLOR);
    assign o_plot   = r_valid_d && !r_off_d && !w_key;
    assign o_color  = r_valid_d ? i_rd_color : '0;
    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_busy   = w_busy;
    assign o_done   = w_done;
    assign o_rd_sel = r_sel;
    assign o_rd_x   = w_rd_x;
    assign o_rd_y   = w_rd_y;

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Scoreboard bench: two engines (colour key on / off) share stimulus, each fed by its own ROM model.
module tb_sprite_draw_engine;

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        int cyc;
        int n0;
        int n1;
    } done_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  mask  = '0;
    logic [35:0] px    = '0;
    logic [35:0] py    = '0;

    logic       busy     [2];
    logic       done     [2];
    logic       plot     [2];
    logic [1:0] rd_sel   [2];
    logic [3:0] rd_x     [2];
    logic [2:0] rd_y     [2];
    logic [2:0] rd_color [2] = '{3'd0, 3'd0};
    logic [8:0] ox       [2];
    logic [8:0] oy       [2];
    logic [2:0] ocol     [2];

    int   checks   = 0;
    int   failures = 0;
    int   ncyc     = 0;
    int   mode     = 0;
    int   seed     = 0;
    int   seen0    = 0;
    int   seen1    = 0;
    pix_t q0[$];
    pix_t q1[$];
    done_t dq[$];

    always #5 clk = ~clk;
    always @(posedge clk) ncyc++;

    sprite_draw_engine #(.TRANSPARENT_EN(1'b1)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_enable_mask(mask),
        .i_pos_x(px), .i_pos_y(py), .o_busy(busy[0]), .o_done(done[0]),
        .o_rd_sel(rd_sel[0]), .o_rd_x(rd_x[0]), .o_rd_y(rd_y[0]), .i_rd_color(rd_color[0]),
        .o_plot(plot[0]), .o_x(ox[0]), .o_y(oy[0]), .o_color(ocol[0])
    );

    sprite_draw_engine #(.TRANSPARENT_EN(1'b0)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_enable_mask(mask),
        .i_pos_x(px), .i_pos_y(py), .o_busy(busy[1]), .o_done(done[1]),
        .o_rd_sel(rd_sel[1]), .o_rd_x(rd_x[1]), .o_rd_y(rd_y[1]), .i_rd_color(rd_color[1]),
        .o_plot(plot[1]), .o_x(ox[1]), .o_y(oy[1]), .o_color(ocol[1])
    );

    // Sprite ROM contents: flat colour, key colour on even columns, or a per-channel pattern.
    function automatic logic [2:0] rom(input int md, input int sd, input int ch, input int rx, input int ry);
        if (md == 0) return 3'b010;
        if (md == 1) return (rx % 2 == 0) ? 3'b101 : 3'b010;
        return 3'(ch * 3 + rx * 5 + ry * 7 + sd);
    endfunction

    always @(posedge clk) begin
        rd_color[0] <= rom(mode, seed, int'(rd_sel[0]), int'(rd_x[0]), int'(rd_y[0]));
        rd_color[1] <= rom(mode, seed, int'(rd_sel[1]), int'(rd_x[1]), int'(rd_y[1]));
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, ncyc);
        end
    endtask

    task automatic chk_pix(input int d, input logic [8:0] ax, input logic [8:0] ay, input logic [2:0] ac);
        pix_t e;
        checks++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            failures++;
            $display("FAIL plot_unexpected dut%0d: got x=%0d y=%0d color=%0d, expected no plot", d, ax, ay, ac);
        end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (ax != e.x || ay != e.y || ac != e.c) begin
                failures++;
                $display("FAIL plot_pixel dut%0d: got x=%0d y=%0d color=%0d, expected x=%0d y=%0d color=%0d",
                         d, ax, ay, ac, e.x, e.y, e.c);
            end
        end
    endtask

    // Monitor: every plot and done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        done_t de;
        if (plot[0]) begin chk_pix(0, ox[0], oy[0], ocol[0]); seen0++; end
        if (plot[1]) begin chk_pix(1, ox[1], oy[1], ocol[1]); seen1++; end
        if (done[0] || done[1]) begin
            checks++;
            if (dq.size() == 0) begin
                failures++;
                $display("FAIL done_unexpected: got done at cycle %0d, expected none", ncyc);
            end else begin
                de = dq.pop_front();
                if (!(done[0] && done[1]) || ncyc != de.cyc || seen0 != de.n0 || seen1 != de.n1) begin
                    failures++;
                    $display("FAIL done_pass: got done=%0d/%0d cyc=%0d plots=%0d/%0d, expected cyc=%0d plots=%0d/%0d",
                             done[0], done[1], ncyc, seen0, seen1, de.cyc, de.n0, de.n1);
                end
            end
            seen0 = 0;
            seen1 = 0;
        end
        if (rst) begin
            seen0 = 0;
            seen1 = 0;
        end
    end

    // Reference model: channels ascending, pixels row-major, clip at screen edge, key drop on dut0 only.
    task automatic push_pass(input logic [3:0] m, input int c0, input int limit);
        int    k = 0;
        int    n0 = 0;
        int    n1 = 0;
        int    idx = 0;
        done_t de;
        for (int ch = 0; ch < 4; ch++) begin
            if (m[ch]) begin
                k++;
                for (int ry = 0; ry < 6; ry++) begin
                    for (int rx = 0; rx < 10; rx++) begin
                        int         sx = int'(px[ch*9 +: 9]) + rx;
                        int         sy = int'(py[ch*9 +: 9]) + ry;
                        logic [2:0] c  = rom(mode, seed, ch, rx, ry);
                        if ((limit < 0 || idx < limit) && sx < 320 && sy < 240) begin
                            q1.push_back('{9'(sx), 9'(sy), c});
                            n1++;
                            if (c != 3'b101) begin
                                q0.push_back('{9'(sx), 9'(sy), c});
                                n0++;
                            end
                        end
                        idx++;
                    end
                end
            end
        end
        if (limit < 0) begin
            de.cyc = c0 + 2 + k * 61;
            de.n0  = n0;
            de.n1  = n1;
            dq.push_back(de);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(input int c0, input int n);
        while (ncyc < c0 + n) step(1);
    endtask

    task automatic start_pass(input logic [3:0] m, input int md, output int c0);
        mask  = m;
        mode  = md;
        seed  = $urandom_range(0, 7);
        start = 1'b1;
        c0    = ncyc;
        push_pass(m, c0, -1);
        step(1);
        start = 1'b0;
        chk("busy_after_start", int'(busy[0]), 1);
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (!done[0] && i < budget) begin
            step(1);
            i++;
        end
        checks++;
        if (!done[0]) begin
            failures++;
            $display("FAIL done_timeout: no done after %0d cycles, expected within %0d", i, budget);
        end else begin
            chk("busy_in_done", int'(busy[0]), 1);
            step(1);
            chk("busy_after_done", int'(busy[0] | busy[1]), 0);
        end
    endtask

    task automatic set_pos(input int ch, input int x, input int y);
        px[ch*9 +: 9] = 9'(x);
        py[ch*9 +: 9] = 9'(y);
    endtask

    initial begin
        int c0;
        int dlen;
        rst = 1'b1;
        step(3);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_done", int'(done[0]), 0);
        chk("rst_plot", int'(plot[0] | plot[1]), 0);
        chk("rst_x", int'(ox[0]), 0);
        chk("rst_y", int'(oy[0]), 0);
        chk("rst_color", int'(ocol[0]), 0);
        chk("rst_rd_sel", int'(rd_sel[0]), 0);
        chk("rst_rd_xy", int'(rd_x[0]) + int'(rd_y[0]), 0);
        rst = 1'b0;
        step(2);

        px = '0; py = '0; set_pos(0, 20, 20);
        start_pass(4'b0001, 0, c0);
        wait_done(200);

        px = '0; py = '0; set_pos(1, 120, 30); set_pos(3, 0, 0);
        start_pass(4'b1010, 2, c0);
        goto_cyc(c0, 2);
        chk("rd_sel_first", int'(rd_sel[0]), 1);
        goto_cyc(c0, 63);
        chk("rd_sel_second", int'(rd_sel[0]), 3);
        wait_done(200);

        px = '0; py = '0; set_pos(0, 315, 237);
        start_pass(4'b0001, 0, c0);
        wait_done(200);

        px = '0; py = '0; set_pos(0, 20, 20);
        start_pass(4'b0001, 1, c0);
        wait_done(200);

        start_pass(4'b0000, 0, c0);
        wait_done(20);

        // Start pulses and input changes during a pass must not disturb it.
        start_pass(4'b0001, 2, c0);
        goto_cyc(c0, 10);
        mask = 4'b1111; set_pos(0, 100, 100); start = 1'b1;
        step(1);
        start = 1'b0;
        goto_cyc(c0, 20);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(200);

        // Start held high: second pass begins in the IDLE cycle right after DONE.
        px = '0; py = '0; set_pos(0, 300, 10); set_pos(2, 50, 200);
        mask = 4'b0101; mode = 2; seed = 3;
        dlen = 2 + 2 * 61;
        start = 1'b1;
        c0 = ncyc;
        push_pass(mask, c0, -1);
        push_pass(mask, c0 + dlen + 1, -1);
        goto_cyc(c0, dlen);
        chk("held_first_done", int'(done[0]), 1);
        goto_cyc(c0, dlen + 1);
        chk("held_idle_gap", int'(busy[0]), 0);
        goto_cyc(c0, dlen + 2);
        start = 1'b0;
        chk("held_restart", int'(busy[0]), 1);
        wait_done(300);

        // Reset during cycle 30 of a pass: 28 pixels already out, no done.
        px = '0; py = '0; set_pos(0, 20, 20);
        mask = 4'b0001; mode = 0;
        start = 1'b1;
        c0 = ncyc;
        push_pass(mask, c0, 28);
        step(1);
        start = 1'b0;
        goto_cyc(c0, 30);
        rst = 1'b1;
        step(1);
        chk("abort_plot", int'(plot[0] | plot[1]), 0);
        chk("abort_busy", int'(busy[0] | busy[1]), 0);
        chk("abort_done", int'(done[0] | done[1]), 0);
        rst = 1'b0;
        step(1);
        chk("abort_drained", q0.size() + q1.size(), 0);
        start_pass(4'b0001, 0, c0);
        wait_done(200);

        for (int it = 0; it < 10; it++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 1) == 1) set_pos(ch, $urandom_range(300, 511), $urandom_range(225, 511));
                else                           set_pos(ch, $urandom_range(0, 319), $urandom_range(0, 239));
            end
            start_pass(4'($urandom_range(0, 15)), $urandom_range(0, 2), c0);
            wait_done(400);
            step($urandom_range(1, 3));
        end

        step(3);
        chk("final_plots_left", q0.size() + q1.size(), 0);
        chk("final_done_left", dq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
